iob_pfsm_in_sync: RTL
=====================

# iob_pfsm_in_sync

Input conditioning stage placed directly upstream of the programmable FSM. It takes up to INPUT_W asynchronous external signals, synchronizes each bit into the clock domain, optionally debounces it with a software-programmable hold time, and drives the FSM input bus with a stable, glitch-free vector. It also produces per-bit rise and fall pulses and an any-change pulse for interrupt or event logic.

## Interface
- INPUT_W, 8: number of conditioned input bits; matches the FSM input bus width.
- SYNC_STAGES, 2: synchronizer flops per bit; legal range 2 or more.
- DBNC_W, 16: debounce counter and limit width.
- clk_i  input  1  system clock.
- arst_n_i  input  1  reset; asynchronous, active-low.
- cke_i  input  1  clock enable; when low, every register holds its value.
- rst_i  input  1  synchronous soft reset, active-high, qualified by cke_i.
- dbnc_limit_i  input  DBNC_W  debounce hold count, shared by all bits.
- in_i  input  INPUT_W  raw asynchronous inputs.
- input_ports_o  output  INPUT_W  conditioned vector to the FSM; reset 0.
- rise_o  output  INPUT_W  one-cycle pulse per bit on a 0→1 change of input_ports_o; reset 0.
- fall_o  output  INPUT_W  one-cycle pulse per bit on a 1→0 change of input_ports_o; reset 0.
- change_o  output  1  OR of rise_o and fall_o; reset 0.

## Operation
- **Synchronizer.** Each bit of in_i passes through a SYNC_STAGES-deep flop chain. The last stage is sync[i]. The chain resets to 0.
- **Debounce, per bit.** Each bit has a counter cnt[i] (DBNC_W wide, reset 0) and a stable bit stb[i] (reset 0). On each enabled edge:
  - If sync[i]==stb[i]: cnt[i] <= 0.
  - Else if cnt[i] >= dbnc_limit_i: stb[i] <= sync[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- **Counter range.** The counter never exceeds dbnc_limit_i, so it cannot wrap.
- **Limit 0.** A change is accepted on the first edge after it reaches sync[i].
- **Bounce handling.** Any return of sync[i] to stb[i] before acceptance clears cnt[i]. A bounce shorter than dbnc_limit_i+1 cycles therefore never reaches the output.
- **Outputs.** input_ports_o = stb. On the edge where stb[i] changes, rise_o[i] and fall_o[i] are registered to reflect that change. They clear on the next enabled edge with no change.
- **Independence.** Bits debounce independently. Several bits may change on the same edge, and change_o is a single pulse in that case.
- **Limit changes.** A change to dbnc_limit_i takes effect immediately. Lowering it below an in-progress cnt[i] causes acceptance on the next edge.
- **Soft reset.** rst_i (with cke_i high) clears the sync chain, counters, stb and pulses to 0 on that edge, overriding all other updates. Async reset does the same at any time, including mid-count.

## Timing
- **Latency.** From an in_i change that is settled before edge k, input_ports_o changes after edge k+SYNC_STAGES+dbnc_limit_i. That is SYNC_STAGES+dbnc_limit_i+1 edges, counting edge k.
- **Pulse alignment.** rise_o, fall_o and change_o are asserted in the same cycle input_ports_o first shows the new value. The pulse lasts exactly one enabled cycle.
- **Clock enable.** With cke_i low, all state freezes, including pulses. The FSM shares cke_i, so it sees each pulse once.
- **Output logic.** All outputs come straight from flops, with no combinational path from inputs to outputs.

## Configuration
- **With IOB_PFSM_IN_SYNC_DBNC_EN defined:** debounce logic as described above.
- **Without it:**
  - Counters are removed and dbnc_limit_i is ignored; the port is kept for interface stability.
  - stb[i] <= sync[i] every enabled edge.
  - Latency is SYNC_STAGES+1 edges.
  - Pulse behaviour is unchanged.

## Structure
- **Shared package/header:** default widths (INPUT_W, SYNC_STAGES, DBNC_W) and the minimum SYNC_STAGES constant. The FSM top uses these same values.
- **Sub-module iob_pfsm_dbnc_bit:** one synchronizer chain, counter and stable bit, plus its rise/fall pulse flops. It is generated INPUT_W times.
- **Top level:** ORs the per-bit pulses into change_o.

## Test plan
- **Reset.** Assert arst_n_i low mid-count with in_i=8'hFF → all outputs are 0 immediately and remain 0 for the first edges after release.
- **Pass-through latency.** dbnc_limit_i=0, SYNC_STAGES=2, in_i 0→8'h01 before edge k → input_ports_o=8'h01 and rise_o=8'h01 after edge k+2. change_o is 1 for exactly one cycle.
- **Bounce rejection.** dbnc_limit_i=4, bit 3 pulses high for 3 cycles → no change on input_ports_o and no pulses. A high level held for 5+ cycles → accepted after k+2+4, with a single rise_o[3].
- **Simultaneous events.** Bit 0 falls and bit 7 rises on the same edge with limit 2 → fall_o=8'h01 and rise_o=8'h80 in the same cycle, with one change_o pulse.
- **Enable and soft reset.** cke_i low for 10 cycles during a pending change → the counter freezes and the pulse is held. rst_i high → all state cleared on that edge.
- **Macro off.** Build without IOB_PFSM_IN_SYNC_DBNC_EN and set dbnc_limit_i=100 → latency is 3 edges and short glitches of one cycle or more pass through.

Source files
------------

// File: rtl/iob_pfsm_in_sync_pkg.sv
// Shared widths for the programmable-FSM input conditioning path.
// Same defaults are used by the FSM top so the buses line up.
package iob_pfsm_in_sync_pkg;

  localparam int INPUT_W_DEF     = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int DBNC_W_DEF      = 16;

  // Clamp a requested synchronizer depth to the safe minimum.
  function automatic int sync_depth(input int n);
    return (n < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : n;
  endfunction

endpackage

// File: rtl/iob_pfsm_dbnc_bit.sv
// One input bit: synchronizer, optional debounce, edge pulses.
// Debounce counter exists only with IOB_PFSM_IN_SYNC_DBNC_EN.
module iob_pfsm_dbnc_bit
  import iob_pfsm_in_sync_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DBNC_W      = DBNC_W_DEF
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic [DBNC_W-1:0] dbnc_limit_i,
  input  logic              in_i,
  output logic              stb_o,
  output logic              rise_o,
  output logic              fall_o,
  output logic              evt_o
);

  localparam int SS = sync_depth(SYNC_STAGES);

  logic [SS-1:0] sync_q;
  logic [SS-1:0] sync_d;
  logic          sync;
  logic          stb_q;
  logic          stb_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;

  assign sync_d = {sync_q[SS-2:0], in_i};
  assign sync   = sync_q[SS-1];

`ifdef IOB_PFSM_IN_SYNC_DBNC_EN
  logic [DBNC_W-1:0] cnt_q;
  logic [DBNC_W-1:0] cnt_d;

  // Accept a new level once it has disagreed for limit+1 edges.
  always_comb begin
    stb_d = stb_q;
    cnt_d = '0;
    if (sync != stb_q) begin
      if (cnt_q >= dbnc_limit_i) begin
        stb_d = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Hold counter; cleared on async or soft reset.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
    end else if (cke_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
  end
`else
  logic unused_limit;
  assign unused_limit = ^dbnc_limit_i;

  // No debounce: stable bit follows the synchronizer.
  always_comb begin
    stb_d = sync;
  end
`endif

  assign rise_d = stb_d & ~stb_q;
  assign fall_d = ~stb_d & stb_q;

  // Synchronizer chain, stable bit and pulse registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= '0;
      stb_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) begin
        sync_q <= '0;
        stb_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        stb_q  <= stb_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end
  end

  assign stb_o  = stb_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign evt_o  = rise_d | fall_d;

endmodule

// File: rtl/iob_pfsm_in_sync.sv
// Input conditioning for the programmable FSM input bus.
// Optional debounce: define IOB_PFSM_IN_SYNC_DBNC_EN.
module iob_pfsm_in_sync
  import iob_pfsm_in_sync_pkg::*;
#(
  parameter int INPUT_W     = INPUT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DBNC_W      = DBNC_W_DEF
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic               cke_i,
  input  logic               rst_i,
  input  logic [DBNC_W-1:0]  dbnc_limit_i,
  input  logic [INPUT_W-1:0] in_i,
  output logic [INPUT_W-1:0] input_ports_o,
  output logic [INPUT_W-1:0] rise_o,
  output logic [INPUT_W-1:0] fall_o,
  output logic               change_o
);

  logic [INPUT_W-1:0] evt;
  logic               change_q;
  logic               change_d;

  for (genvar i = 0; i < INPUT_W; i++) begin : g_bit
    iob_pfsm_dbnc_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DBNC_W      (DBNC_W)
    ) u_bit (
      .clk_i        (clk_i),
      .arst_n_i     (arst_n_i),
      .cke_i        (cke_i),
      .rst_i        (rst_i),
      .dbnc_limit_i (dbnc_limit_i),
      .in_i         (in_i[i]),
      .stb_o        (input_ports_o[i]),
      .rise_o       (rise_o[i]),
      .fall_o       (fall_o[i]),
      .evt_o        (evt[i])
    );
  end

  assign change_d = |evt;

  // Registered any-change pulse, aligned with the per-bit pulses.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      change_q <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) change_q <= 1'b0;
      else       change_q <= change_d;
    end
  end

  assign change_o = change_q;

endmodule
